// File: rtl/int8_mac_pkg.sv
// Shared definitions for the INT8 dot-product MAC execution unit and its decoder.
package int8_mac_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int PROD_W = 2 * LANE_W;

  // Codes 4..7 are left undefined on purpose; they execute as DOT4 without write-back.
  typedef enum logic [2:0] {
    DOT4    = 3'd0,
    DOT4A   = 3'd1,
    DOT4ACC = 3'd2,
    ACCCLR  = 3'd3
  } opcode_e;

endpackage

// File: rtl/int8_mac_dot4_mul.sv
// Four independent signed 8x8 lane multipliers, purely combinational.
module int8_mac_dot4_mul
  import int8_mac_pkg::*;
(
  input  logic        [LANES*LANE_W-1:0] a,
  input  logic        [LANES*LANE_W-1:0] b,
  output logic signed [PROD_W-1:0]       prod [LANES]
);

  function automatic logic signed [PROD_W-1:0] lane_mul(input logic [LANE_W-1:0] x,
                                                        input logic [LANE_W-1:0] y);
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] ys;
    xs = {{LANE_W{x[LANE_W-1]}}, x};
    ys = {{LANE_W{y[LANE_W-1]}}, y};
    return xs * ys;
  endfunction

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = lane_mul(a[k*LANE_W +: LANE_W], b[k*LANE_W +: LANE_W]);
    end
  end

endmodule

// File: rtl/int8_mac_exec.sv
// Two-stage CV-X-IF execution unit for packed INT8 dot products with a private accumulator.
module int8_mac_exec
  import int8_mac_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter type opcode_t = int8_mac_pkg::opcode_e,
  parameter type hartid_t = logic,
  parameter type id_t     = logic
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] registers_i [3],
  input  opcode_t         opcode_i,
  input  hartid_t         hartid_i,
  input  id_t             id_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_data_o,
  output logic [4:0]      result_rd_o,
  output id_t             result_id_o,
  output hartid_t         result_hartid_o,
  output logic            result_we_o
);

  function automatic logic signed [XLEN-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(XLEN-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic signed [XLEN-1:0] wrap_add(input logic signed [XLEN-1:0] x,
                                                      input logic signed [XLEN-1:0] y);
    return x + y;
  endfunction

  logic signed [PROD_W-1:0] prod_w    [LANES];
  logic signed [PROD_W-1:0] prod_p1_q [LANES];
  logic signed [PROD_W-1:0] prod_p1_d [LANES];
  opcode_t                  op_p1_q, op_p1_d;
  logic [XLEN-1:0]          rs3_p1_q, rs3_p1_d;
  logic [4:0]               rd_p1_q, rd_p1_d;
  id_t                      id_p1_q, id_p1_d;
  hartid_t                  hart_p1_q, hart_p1_d;
  logic                     vld_p1_q, vld_p1_d;

  logic                     vld_p2_q, vld_p2_d;
  logic [XLEN-1:0]          data_p2_q, data_p2_d;
  logic [4:0]               rd_p2_q, rd_p2_d;
  id_t                      id_p2_q, id_p2_d;
  hartid_t                  hart_p2_q, hart_p2_d;
  logic                     we_p2_q, we_p2_d;
  logic signed [XLEN-1:0]   acc_q, acc_d;

  logic                     s2_free, accept, advance;
  logic signed [XLEN-1:0]   dot4, op_res, acc_next;
  logic                     op_we;

  int8_mac_dot4_mul u_mul (
    .a    (registers_i[0][LANES*LANE_W-1:0]),
    .b    (registers_i[1][LANES*LANE_W-1:0]),
    .prod (prod_w)
  );

  // Handshake: S2 frees on retire, S1 drains into a free S2, flush blocks new work.
  assign s2_free    = !vld_p2_q || result_ready_i;
  assign in_ready_o = rst_ni && !flush_i && (!vld_p1_q || s2_free);
  assign accept     = in_valid_i && in_ready_o;
  assign advance    = vld_p1_q && s2_free && !flush_i;

  // ---- S1 -> S2: lane sum and operation select ----
  always_comb begin
    dot4 = '0;
    for (int k = 0; k < LANES; k++) begin
      dot4 = wrap_add(dot4, sext_prod(prod_p1_q[k]));
    end
  end

  always_comb begin
    op_res   = dot4;
    op_we    = 1'b1;
    acc_next = acc_q;
    case (op_p1_q)
      DOT4:    op_res = dot4;
      DOT4A:   op_res = wrap_add($signed(rs3_p1_q), dot4);
      DOT4ACC: begin
        acc_next = wrap_add(acc_q, dot4);
        op_res   = acc_next;
      end
      ACCCLR:  begin
        op_res   = acc_q;
        acc_next = '0;
      end
      default: op_we = 1'b0;
    endcase
  end

  always_comb begin
    vld_p1_d  = vld_p1_q;
    prod_p1_d = prod_p1_q;
    op_p1_d   = op_p1_q;
    rs3_p1_d  = rs3_p1_q;
    rd_p1_d   = rd_p1_q;
    id_p1_d   = id_p1_q;
    hart_p1_d = hart_p1_q;
    if (flush_i) begin
      vld_p1_d = 1'b0;
    end else if (accept) begin
      vld_p1_d  = 1'b1;
      prod_p1_d = prod_w;
      op_p1_d   = opcode_i;
      rs3_p1_d  = registers_i[2];
      rd_p1_d   = rd_i;
      id_p1_d   = id_i;
      hart_p1_d = hartid_i;
    end else if (advance) begin
      vld_p1_d = 1'b0;
    end
  end

  // The accumulator moves only when an instruction enters S2, so chained DOT4ACC never stalls.
  always_comb begin
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    rd_p2_d   = rd_p2_q;
    id_p2_d   = id_p2_q;
    hart_p2_d = hart_p2_q;
    we_p2_d   = we_p2_q;
    acc_d     = acc_q;
    if (flush_i) begin
      vld_p2_d = 1'b0;
    end else if (advance) begin
      vld_p2_d  = 1'b1;
      data_p2_d = op_res;
      we_p2_d   = op_we;
      rd_p2_d   = rd_p1_q;
      id_p2_d   = id_p1_q;
      hart_p2_d = hart_p1_q;
      acc_d     = acc_next;
    end else if (result_ready_i) begin
      vld_p2_d = 1'b0;
    end
  end

  // ---- S1 register: operand products and instruction fields ----
  always_ff @(posedge clk_i) begin
    prod_p1_q <= prod_p1_d;
    op_p1_q   <= op_p1_d;
    rs3_p1_q  <= rs3_p1_d;
    rd_p1_q   <= rd_p1_d;
    id_p1_q   <= id_p1_d;
    hart_p1_q <= hart_p1_d;
  end

  // ---- S2 register: valids, accumulator and result ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      acc_q     <= '0;
      data_p2_q <= '0;
      rd_p2_q   <= '0;
      id_p2_q   <= '0;
      hart_p2_q <= '0;
      we_p2_q   <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      acc_q     <= acc_d;
      data_p2_q <= data_p2_d;
      rd_p2_q   <= rd_p2_d;
      id_p2_q   <= id_p2_d;
      hart_p2_q <= hart_p2_d;
      we_p2_q   <= we_p2_d;
    end
  end

  assign result_valid_o  = vld_p2_q;
  assign result_data_o   = data_p2_q;
  assign result_rd_o     = rd_p2_q;
  assign result_id_o     = id_p2_q;
  assign result_hartid_o = hart_p2_q;
  assign result_we_o     = we_p2_q;

endmodule

// File: tb/tb_int8_mac_exec.sv
// Directed bench for int8_mac_exec with a program-order reference model and literal pins.
module tb_int8_mac_exec;
  import int8_mac_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] regs [3];
  opcode_e         opcode;
  logic            hartid, id;
  logic [4:0]      rd;
  logic            flush;
  logic            res_valid, res_ready;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_rd;
  logic            res_id, res_hartid, res_we;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [4:0]  rd;
    logic        id;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [4:0]  rd;
    int          cyc;
    int          lat;
  } ret_t;

  exp_t        q[$];
  ret_t        log_q[$];
  logic [31:0] macc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int8_mac_exec #(.XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .registers_i    (regs),
    .opcode_i       (opcode),
    .hartid_i       (hartid),
    .id_i           (id),
    .rd_i           (rd),
    .flush_i        (flush),
    .result_valid_o (res_valid),
    .result_ready_i (res_ready),
    .result_data_o  (res_data),
    .result_rd_o    (res_rd),
    .result_id_o    (res_id),
    .result_hartid_o(res_hartid),
    .result_we_o    (res_we)
  );

  function automatic int dot4_model(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: results computed in program order at acceptance, checked every valid cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   d;
    if (!rst_n) begin
      q.delete();
      macc = 0;
      check("reset_result_valid", res_valid, 0);
      check("reset_in_ready", in_ready, 0);
    end else begin
      if (res_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data 0x%0h, expected no result", res_data);
        end else begin
          check("res_data", res_data, q[0].data);
          check("res_fields", {res_we, res_rd, res_id, res_hartid},
                {q[0].we, q[0].rd, q[0].id, q[0].id});
          if (res_ready) begin
            log_q.push_back('{res_data, res_we, res_rd, cyc, cyc - q[0].acc_cyc});
            void'(q.pop_front());
          end
        end
      end
      if (flush) begin
        check("flush_blocks_input", in_ready, 0);
        q.delete();
      end
      if (in_valid && in_ready) begin
        d = dot4_model(regs[0], regs[1]);
        e.we = 1'b1;
        e.rd = rd;
        e.id = id;
        e.acc_cyc = cyc;
        case (opcode)
          DOT4:    e.data = d;
          DOT4A:   e.data = regs[2] + d;
          DOT4ACC: begin macc = macc + d; e.data = macc; end
          ACCCLR:  begin e.data = macc; macc = 0; end
          default: begin e.data = d; e.we = 1'b0; end
        endcase
        q.push_back(e);
      end
    end
  end

  task automatic set_in(input opcode_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [4:0] r);
    opcode  = op;
    regs[0] = a;
    regs[1] = b;
    regs[2] = c;
    rd      = r;
    id      = r[0];
    hartid  = r[0];
    in_valid = 1'b1;
  endtask

  task automatic send(input opcode_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [4:0] r);
    int n;
    n = 0;
    set_in(op, a, b, c, r);
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          guard;
    logic [7:0]  lane;
    in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
    regs[0] = '0; regs[1] = '0; regs[2] = '0;
    opcode = DOT4; rd = '0; id = 1'b0; hartid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_after_reset", in_ready, 1);
    check("valid_after_reset", res_valid, 0);

    // DOT4 basic with latency
    log_q.delete();
    send(DOT4, 32'h01020304, 32'h01010101, 32'h0, 5'd1);
    in_valid = 1'b0;
    wait_cycles(4);
    check("t1_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("t1_data", log_q[0].data, 32'h0000000A);
      check("t1_we", log_q[0].we, 1);
      check("t1_latency", log_q[0].lat, 2);
    end

    // Most-negative lanes and DOT4A wrap
    log_q.delete();
    send(DOT4, 32'h80808080, 32'h7F7F7F7F, 32'h0, 5'd2);
    send(DOT4A, 32'h01000000, 32'h01000000, 32'h7FFFFFFF, 5'd3);
    in_valid = 1'b0;
    wait_cycles(4);
    check("t2_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("t2_dot4_neg", log_q[0].data, 32'hFFFF0200);
      check("t2_dot4a_wrap", log_q[1].data, 32'h80000000);
      check("t2_rd", log_q[1].rd, 5'd3);
    end

    // ACCCLR then three back-to-back DOT4ACC
    log_q.delete();
    send(ACCCLR, 32'h0, 32'h0, 32'h0, 5'd4);
    for (int i = 0; i < 3; i++) send(DOT4ACC, 32'h01020304, 32'h01010101, 32'h0, 5'd5 + 5'(i));
    in_valid = 1'b0;
    wait_cycles(5);
    check("t3_count", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t3_acc_data", log_q[i].data, 32'(10 * i));
      check("t3_consecutive", log_q[3].cyc - log_q[0].cyc, 3);
    end

    // Backpressure: three offered, two accepted while result_ready is low
    log_q.delete();
    res_ready = 1'b0;
    n = 0;
    set_in(DOT4, 32'h01010101, 32'h01010101, 32'h0, 5'd10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk);
      #1;
      lane = 8'(n + 1);
      if (n < 3) set_in(DOT4, {4{lane}}, 32'h01010101, 32'h0, 5'(10 + n));
      else in_valid = 1'b0;
    end
    check("bp_accepts", n, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_none_retired", log_q.size(), 0);
    res_ready = 1'b1;
    guard = 0;
    while (n < 3 && guard < 20) begin
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    wait_cycles(5);
    check("bp_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("bp_data", log_q[i].data, 32'(4 * (i + 1)));
        check("bp_rd", log_q[i].rd, 5'(10 + i));
      end
    end

    // Flush with both stages occupied; new input offered during flush
    log_q.delete();
    res_ready = 1'b0;
    send(DOT4, 32'h01020304, 32'h01010101, 32'h0, 5'd20);
    send(DOT4, 32'h01020304, 32'h01010101, 32'h0, 5'd21);
    set_in(DOT4, 32'h01020304, 32'h01010101, 32'h0, 5'd22);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_cycles(4);
    check("flush_no_results", log_q.size(), 0);
    check("flush_valid_low", res_valid, 0);

    // Undefined opcode: no write-back, acc untouched by it or by the flush
    log_q.delete();
    send(opcode_e'(3'd5), 32'h01020304, 32'h01010101, 32'h0, 5'd7);
    send(ACCCLR, 32'h0, 32'h0, 32'h0, 5'd8);
    in_valid = 1'b0;
    wait_cycles(4);
    check("t5_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("undef_data", log_q[0].data, 32'h0000000A);
      check("undef_we", log_q[0].we, 0);
      check("accclr_old_acc", log_q[1].data, 32'd30);
    end

    // Reset pulse with two DOT4ACC in flight
    log_q.delete();
    res_ready = 1'b0;
    send(DOT4ACC, 32'h01020304, 32'h01010101, 32'h0, 5'd12);
    send(DOT4ACC, 32'h01020304, 32'h01010101, 32'h0, 5'd13);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    res_ready = 1'b1;
    wait_cycles(4);
    check("rst_no_results", log_q.size(), 0);
    check("rst_valid_low", res_valid, 0);
    send(DOT4ACC, 32'h00000005, 32'h01010101, 32'h0, 5'd14);
    in_valid = 1'b0;
    wait_cycles(4);
    check("rst_count", log_q.size(), 1);
    if (log_q.size() >= 1) check("rst_acc_fresh", log_q[0].data, 32'd5);

    check("all_retired", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
